// File: rtl/hdec_pkg.sv
// hdec_pkg: shared widths and convergent round/saturate for the half-band output stages
package hdec_pkg;
  localparam int WIN_DEF = 20;
  localparam int WOUT_DEF = 12;
  localparam int SHIFT_DEF = 8;
  localparam int TAPS = 21;
  typedef struct packed {
    logic sat;
    logic signed [31:0] y;
  } rs_t;
  // Half-to-even: bias by half-minus-one plus the kept LSB; two spare bits avoid overflow
  function automatic rs_t round_sat(input logic signed [31:0] x, input int shift, input int wout);
    logic signed [33:0] xe, b, h, r, mx, mn;
    rs_t o;
    xe = 34'(x);
    b = {33'b0, x[shift[4:0]]};
    h = 34'sd1 <<< (shift - 1);
    r = (xe + h - 34'sd1 + b) >>> shift;
    mx = (34'sd1 <<< (wout - 1)) - 34'sd1;
    mn = -mx - 34'sd1;
    o.sat = (r > mx) || (r < mn);
    o.y = (r > mx) ? mx[31:0] : (r < mn) ? mn[31:0] : r[31:0];
    return o;
  endfunction
endpackage

// File: rtl/hdec_decim_round_out_if.sv
// hdec_decim_round_out_if: valid/ready sample stream toward the next polyphase stage
interface hdec_decim_round_out_if
  import hdec_pkg::*;
#(
  parameter int WOUT = WOUT_DEF
);
  logic signed [WOUT-1:0] y_out;
  logic y_valid;
  logic y_ready;
  modport master(output y_out, y_valid, input y_ready);
  modport slave(input y_out, y_valid, output y_ready);
endinterface

// File: rtl/hdec_out_fifo.sv
// hdec_out_fifo: synchronous show-ahead FIFO; output holds the last popped value when empty
module hdec_out_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [LW-1:0] cnt;
  logic [W-1:0] last;
  logic do_pop, do_push;
  assign empty = cnt == '0;
  assign full = cnt == LW'(DEPTH);
  assign level = cnt;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? last : mem[rd];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      last <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) begin
        rd <= rd + 1'b1;
        last <= mem[rd];
      end
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/hdec_decim_round_out.sv
// hdec_decim_round_out: warm-up discard, decimate, round/saturate and buffer FIR output
module hdec_decim_round_out
  import hdec_pkg::*;
#(
  parameter int WIN = WIN_DEF,
  parameter int WOUT = WOUT_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DECIM = 2,
  parameter int PHASE = 0,
  parameter int WARMUP = TAPS,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [WIN-1:0]  x_in,
  input  logic                   x_valid,
  hdec_decim_round_out_if.master y,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  input  logic                   flag_clr
);
  localparam int WW = $clog2(WARMUP + 2);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  logic [WW-1:0] warm;
  logic [PW-1:0] ph;
  logic s1_v;
  logic [WOUT-1:0] s1_y;
  rs_t rs;
  logic unused_hi;
  logic warm_done, keep, full, empty, pop;
  assign warm_done = warm == WW'(WARMUP);
  assign keep = x_valid && warm_done && ph == PW'(PHASE);
  assign rs = round_sat(32'(x_in), SHIFT, WOUT);
  assign unused_hi = ^rs.y[31:WOUT];
  assign y.y_valid = !empty;
  assign pop = y.y_valid && y.y_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      warm <= '0;
      ph <= '0;
      s1_v <= 1'b0;
      s1_y <= '0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (x_valid && !warm_done) warm <= warm + 1'b1;
      if (x_valid && warm_done) ph <= (ph == PW'(DECIM - 1)) ? '0 : ph + 1'b1;
      s1_v <= keep;
      if (keep) s1_y <= rs.y[WOUT-1:0];
      sat_flag <= (sat_flag && !flag_clr) || (keep && rs.sat);
      ovf_flag <= (ovf_flag && !flag_clr) || (s1_v && full && !pop);
    end
  end
  hdec_out_fifo #(.W(WOUT), .DEPTH(DEPTH)) u_fifo (
    .clk,
    .reset,
    .push(s1_v),
    .pop,
    .din(s1_y),
    .dout(y.y_out),
    .full,
    .empty,
    .level(fifo_level)
  );
endmodule

// File: tb/tb_hdec_decim_round_out.sv
// tb_hdec_decim_round_out: scenario tasks plus randomized run against a queue-based reference model
module tb_hdec_decim_round_out;
  localparam int DEPTH = 4;
  localparam int DECIM = 2;
  localparam int PHASE = 0;
  localparam int WARMUP = 21;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x_valid = 1'b0;
  logic flag_clr = 1'b0;
  logic signed [19:0] x_in = '0;
  logic [2:0] fifo_level;
  logic sat_flag, ovf_flag;
  int checks = 0;
  int failures = 0;
  hdec_decim_round_out_if #(.WOUT(12)) yif();
  hdec_decim_round_out #(
    .WIN(20), .WOUT(12), .SHIFT(8), .DECIM(DECIM), .PHASE(PHASE), .WARMUP(WARMUP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(rst),
    .x_in(x_in),
    .x_valid(x_valid),
    .y(yif),
    .fifo_level(fifo_level),
    .sat_flag(sat_flag),
    .ovf_flag(ovf_flag),
    .flag_clr(flag_clr)
  );
  always #5 clk = ~clk;
  int q[$];
  bit pv, msat, movf;
  int pval, warm, ph, mlast;
  function automatic void ref_round(input int x, output int yv, output bit s);
    int fl, rem;
    fl = x >>> 8;
    rem = x - fl * 256;
    if (rem > 128 || (rem == 128 && (fl % 2) != 0)) fl++;
    s = fl > 2047 || fl < -2048;
    yv = fl > 2047 ? 2047 : fl < -2048 ? -2048 : fl;
  endfunction
  function automatic bit e_valid();
    return q.size() > 0;
  endfunction
  function automatic logic [11:0] e_out();
    return 12'(q.size() > 0 ? q[0] : mlast);
  endfunction
  task automatic model_edge();
    bit pop, keep, s, ovf_ev;
    int yv;
    if (rst) begin
      q.delete();
      pv = 0; pval = 0; warm = 0; ph = 0; msat = 0; movf = 0; mlast = 0;
      return;
    end
    pop = q.size() > 0 && yif.y_ready;
    if (pop) mlast = q.pop_front();
    ovf_ev = 0;
    if (pv) begin
      if (q.size() < DEPTH) q.push_back(pval);
      else ovf_ev = 1;
    end
    keep = 0;
    if (x_valid) begin
      if (warm < WARMUP) warm++;
      else begin
        keep = ph == PHASE;
        ph = (ph + 1) % DECIM;
      end
    end
    ref_round(int'(x_in), yv, s);
    msat = (msat && !flag_clr) || (keep && s);
    movf = (movf && !flag_clr) || ovf_ev;
    pv = keep;
    pval = yv;
  endtask
  task automatic step(input bit v, input int x, input bit rdy, input bit clr);
    x_valid = v;
    x_in = 20'(x);
    yif.y_ready = rdy;
    flag_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic send_kept(input int x, input bit rdy, input bit clr);
    if (ph != PHASE) step(1, int'($urandom_range(0, 1000)), rdy, 0);
    step(1, x, rdy, clr);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(1, 12345, 1, 0);
    rst = 1'b0;
    checks++;
    if (yif.y_valid !== 1'b0 || yif.y_out !== 12'd0) begin
      failures++;
      $display("FAIL reset_out valid=%b y=%0d exp valid=0 y=0", yif.y_valid, yif.y_out);
    end
    checks++;
    if ({fifo_level, sat_flag, ovf_flag} !== 5'd0) begin
      failures++;
      $display("FAIL reset_state level=%0d sat=%b ovf=%b exp 0 0 0", fifo_level, sat_flag, ovf_flag);
    end
  endtask
  task automatic test_warmup();
    for (int i = 0; i < WARMUP; i++) begin
      step(1, 1000, 1, 0);
      checks++;
      if (yif.y_valid !== 1'b0 || fifo_level !== 3'd0) begin
        failures++;
        $display("FAIL warmup_discard i=%0d valid=%b level=%0d exp 0 0", i, yif.y_valid, fifo_level);
      end
    end
    step(1, 256, 1, 0);
    checks++;
    if (yif.y_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early valid=%b exp 0", yif.y_valid);
    end
    step(1, 512, 1, 0);
    checks++;
    if (yif.y_valid !== 1'b1 || yif.y_out !== 12'd1 || fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL first_out valid=%b y=%0d level=%0d exp 1 1 1", yif.y_valid, yif.y_out, fifo_level);
    end
    step(1, 768, 1, 0);
    checks++;
    if (yif.y_valid !== 1'b0 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL drain_one valid=%b level=%0d exp 0 0", yif.y_valid, fifo_level);
    end
    step(1, 1024, 1, 0);
    checks++;
    if (yif.y_valid !== 1'b1 || yif.y_out !== 12'd3 || fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL second_out valid=%b y=%0d level=%0d exp 1 3 1", yif.y_valid, yif.y_out, fifo_level);
    end
    step(0, 0, 1, 0);
  endtask
  task automatic test_rounding();
    int vals[5] = '{384, 640, -384, 383, 385};
    int exps[5] = '{2, 2, -2, 1, 2};
    logic [11:0] ev;
    for (int i = 0; i < 5; i++) begin
      send_kept(vals[i], 1, 0);
      step(0, 0, 1, 0);
      ev = 12'(exps[i]);
      checks++;
      if (yif.y_valid !== 1'b1 || yif.y_out !== ev || sat_flag !== 1'b0) begin
        failures++;
        $display("FAIL round x=%0d valid=%b y=%0d sat=%b exp 1 %0d 0", vals[i], yif.y_valid,
                 $signed(yif.y_out), sat_flag, exps[i]);
      end
    end
  endtask
  task automatic test_saturation();
    send_kept(524287, 1, 0);
    checks++;
    if (sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_set sat=%b exp 1", sat_flag);
    end
    step(0, 0, 1, 0);
    checks++;
    if (yif.y_out !== 12'h7ff || yif.y_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_max y=%0d valid=%b exp 2047 1", $signed(yif.y_out), yif.y_valid);
    end
    step(0, 0, 1, 1);
    checks++;
    if (sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL sat_clr sat=%b exp 0", sat_flag);
    end
    send_kept(-524288, 1, 0);
    step(0, 0, 1, 0);
    checks++;
    if (yif.y_out !== 12'h800 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL sat_min y=%0d sat=%b exp -2048 0", $signed(yif.y_out), sat_flag);
    end
    send_kept(524287, 1, 1);
    checks++;
    if (sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_clr_vs_event sat=%b exp 1", sat_flag);
    end
    step(0, 0, 1, 1);
  endtask
  task automatic test_backpressure();
    repeat (2) step(0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) send_kept(256 * i, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (fifo_level !== 3'd4 || ovf_flag !== 1'b1 || yif.y_out !== 12'd1 || yif.y_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full level=%0d ovf=%b y=%0d valid=%b exp 4 1 1 1", fifo_level, ovf_flag,
               yif.y_out, yif.y_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (yif.y_out !== 12'(i) || yif.y_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_order i=%0d y=%0d valid=%b exp %0d 1", i, yif.y_out, yif.y_valid, i);
      end
      step(0, 0, 1, 0);
    end
    checks++;
    if (yif.y_valid !== 1'b0 || yif.y_out !== 12'd4 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL bp_empty valid=%b y=%0d level=%0d exp 0 4 0", yif.y_valid, yif.y_out, fifo_level);
    end
  endtask
  task automatic test_full_push_pop();
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) send_kept(int'($urandom_range(0, 400000)), 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (fifo_level !== 3'd4 || ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL fpp_fill level=%0d ovf=%b exp 4 0", fifo_level, ovf_flag);
    end
    send_kept(int'($urandom_range(0, 400000)), 0, 0);
    step(0, 0, 1, 0);
    checks++;
    if (fifo_level !== 3'd4 || ovf_flag !== 1'b0 || yif.y_out !== e_out()) begin
      failures++;
      $display("FAIL fpp_both level=%0d ovf=%b y=%0d exp 4 0 %0d", fifo_level, ovf_flag, yif.y_out, e_out());
    end
    repeat (5) step(0, 0, 1, 0);
    checks++;
    if (fifo_level !== 3'd0 || yif.y_out !== e_out()) begin
      failures++;
      $display("FAIL fpp_drain level=%0d y=%0d exp 0 %0d", fifo_level, yif.y_out, e_out());
    end
  endtask
  task automatic test_reset_mid();
    send_kept(524287, 0, 0);
    send_kept(1000, 0, 0);
    send_kept(2000, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (fifo_level !== 3'd3 || sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL mid_prep level=%0d sat=%b exp 3 1", fifo_level, sat_flag);
    end
    rst = 1'b1;
    step(1, 256, 0, 0);
    rst = 1'b0;
    checks++;
    if (yif.y_valid !== 1'b0 || fifo_level !== 3'd0 || sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset valid=%b level=%0d sat=%b ovf=%b exp 0 0 0 0", yif.y_valid, fifo_level,
               sat_flag, ovf_flag);
    end
    for (int i = 0; i < WARMUP; i++) begin
      step(1, int'($urandom_range(1, 300000)), 1, 0);
      checks++;
      if (yif.y_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_warmup i=%0d valid=%b exp 0", i, yif.y_valid);
      end
    end
    step(1, 256, 1, 0);
    step(1, 999, 1, 0);
    checks++;
    if (yif.y_valid !== 1'b1 || yif.y_out !== 12'd1) begin
      failures++;
      $display("FAIL mid_phase valid=%b y=%0d exp 1 1", yif.y_valid, yif.y_out);
    end
    step(0, 0, 1, 0);
  endtask
  task automatic test_random();
    int r, x;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 3));
      x = r == 0 ? int'($urandom_range(0, 1048575)) - 524288 :
          r == 1 ? (int'($urandom_range(0, 64)) - 32) * 128 :
                   int'($urandom_range(0, 65535)) - 32768;
      rst = $urandom_range(0, 199) == 0;
      step($urandom_range(0, 3) != 0, x, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      rst = 1'b0;
      checks++;
      if (yif.y_valid !== e_valid() || yif.y_out !== e_out() || fifo_level !== 3'(q.size())) begin
        failures++;
        $display("FAIL rnd_data n=%0d valid=%b y=%0d level=%0d exp %b %0d %0d", n, yif.y_valid,
                 yif.y_out, fifo_level, e_valid(), e_out(), q.size());
      end
      checks++;
      if (sat_flag !== msat || ovf_flag !== movf) begin
        failures++;
        $display("FAIL rnd_flags n=%0d sat=%b ovf=%b exp %b %b", n, sat_flag, ovf_flag, msat, movf);
      end
    end
  endtask
  initial begin
    yif.y_ready = 1'b0;
    test_reset();
    test_warmup();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hdec_decim_round_out.md
Name: hdec_decim_round_out

Overview:
Output stage directly downstream of the 21-tap half-band decimating FIR (20-bit transposed-form MAC output, one sample per clock).
- Discards the filter's pipeline-fill transient.
- Keeps one of every DECIM samples.
- Applies convergent rounding and saturation to WOUT bits.
- Buffers results in a small FIFO with a valid/ready interface toward the next polyphase stage.

Parameters:
WIN, 20, input (FIR output) width, signed
WOUT, 12, output width, signed
SHIFT, 8, LSBs dropped by rounding (SHIFT >= 1)
DECIM, 2, decimation factor
PHASE, 0, kept phase index, 0..DECIM-1
WARMUP, 21, post-reset valid input samples discarded (filter fill)
DEPTH, 4, FIFO depth (power of 2)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
x_in  in  WIN  signed FIR output sample
x_valid  in  1  x_in valid this cycle
y_out  out  WOUT  signed decimated/rounded sample (FIFO head)
y_valid  out  1  y_out valid
y_ready  in  1  consumer accepts; transfer when y_valid && y_ready
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy
sat_flag  out  1  sticky: a saturation occurred
ovf_flag  out  1  sticky: a kept sample was dropped because the FIFO was full
flag_clr  in  1  clears sat_flag and ovf_flag

Behaviour:
- Reset (synchronous, active-high; also when asserted mid-operation):
  - y_out=0, y_valid=0, fifo_level=0, sat_flag=0, ovf_flag=0.
  - Warm-up counter, phase counter and stage-1 register cleared; FIFO emptied.
  - In-flight samples lost; warm-up restarts.
- Warm-up:
  - Counter counts x_valid cycles up to WARMUP, then saturates.
  - Samples with x_valid during count < WARMUP are discarded.
  - The phase counter does not advance during warm-up.
- Phase select:
  - After warm-up, each x_valid increments the phase counter modulo DECIM (wraps DECIM-1 -> 0).
  - A sample is kept when the phase equals PHASE before the increment, so the first post-warm-up sample has phase 0.
  - x_valid=0 freezes both counters.
- Rounding:
  - Convergent (round-half-to-even) on the SHIFT dropped bits.
  - r = (x + 2^(SHIFT-1) - 1 + x[SHIFT]) >>> SHIFT, computed in WIN+1 bits, so there is no internal overflow.
- Saturation:
  - If r > 2^(WOUT-1)-1, output the max; if r < -2^(WOUT-1), output the min.
  - Either case sets sat_flag on the cycle the result is registered.
- Pipeline:
  - Kept sample captured at edge k.
  - Stage 1 (round + saturate) registered at edge k; FIFO write at edge k+1.
  - If the FIFO was empty, y_valid=1 and y_out is valid after edge k+1: latency 2 clocks.
  - No bypass path.
- FIFO (show-ahead): y_out = head entry.
  - y_out and y_valid stay stable while y_valid && !y_ready.
  - Empty: y_valid=0, and y_out holds its last value (0 after reset).
  - Full with a write and no read: incoming sample dropped, contents unchanged, ovf_flag set.
  - Full with simultaneous read and write: both performed, level unchanged, no overflow.
  - Empty with a write: level goes to 1; a read in the same cycle is ignored because y_valid=0.
  - Pointers wrap modulo DEPTH.
- Flags:
  - Sticky; cleared only by reset or flag_clr.
  - If flag_clr coincides with a new event, the flag is set (the event wins).

Decomposition:
- Shared package hdec_pkg holds:
  - width constants WIN_DEF=20, WOUT_DEF=12, SHIFT_DEF=8
  - tap count 21, which is also the WARMUP default
  - the convergent round/saturate function, reusable by the other polyphase output stages.
- Sub-module hdec_out_fifo: synchronous show-ahead FIFO with push/pop, full/empty and level outputs.
  - It contains no flag logic; ovf detection stays in the parent.

Test Plan:
1. Reset; 21 valid samples of 1000 -> y_valid stays 0. Then x_in = 256, 512, 768, 1024 with PHASE=0 -> outputs 1, 3; fifo_level peaks at 1 with y_ready=1; each output appears 2 clocks after its input.
2. Rounding, with each value in a kept slot: 384 -> 2; 640 -> 2; -384 -> -2; 383 -> 1; 385 -> 2. sat_flag remains 0.
3. Saturation: 524287 -> 2047 and sat_flag=1; -524288 -> -2048 with no new saturation. flag_clr pulse -> sat_flag=0. Then flag_clr together with saturating input 524287 -> sat_flag=1.
4. Backpressure: y_ready=0, 6 kept samples 1..6 (scaled by 256) -> fifo_level=4, ovf_flag=1, y_out held at 1. Raise y_ready -> 1, 2, 3, 4 in order, then y_valid=0.
5. Full plus simultaneous pop and push: FIFO at 4, y_ready=1 on the kept-sample cycle -> level stays 4, ovf_flag unchanged.
6. Reset mid-stream with 3 entries queued -> next cycle y_valid=0, level=0, flags=0. Next 21 valid samples discarded (warm-up restarts) and phase restarts at 0.
